// File: rtl/cpu_pkg.sv
// Shared CPU package: opcode values, fetch/decode FSM state type,
// one-hot control word width and an opcode extraction helper.
package cpu_pkg;

  localparam int unsigned ONEHOT_W = 64;
  localparam int unsigned OP_W     = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd4;
  localparam logic [OP_W-1:0] OP_MOVL = 6'd12;
  localparam logic [OP_W-1:0] OP_MOVS = 6'd13;
  localparam logic [OP_W-1:0] OP_JA   = 6'd14;
  localparam logic [OP_W-1:0] OP_AND  = 6'd25;
  localparam logic [OP_W-1:0] OP_CMP  = 6'd59;
  localparam logic [OP_W-1:0] OP_HALT = 6'd63;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fd_state_t;

  // The opcode always sits in the top six bits of the 16-bit word.
  function automatic logic [OP_W-1:0] op_of16(input logic [15:0] i);
    return i[15 -: OP_W];
  endfunction

endpackage

// File: rtl/onehot_dec6.sv
// 6-to-64 one-hot decoder with enable.
// Ports: code (6b), en, onehot (64b, all-zero when en=0).
module onehot_dec6
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]     code,
  input  logic                en,
  output logic [ONEHOT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: PC, instruction register, BOOT/RUN/HALT FSM.
// Ports: clk, rst_n, imem_addr/rdata, stall, br_taken/target, instr_q, opcode_onehot, valid_q, pc_plus1, halted.
module fetch_decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W    = 8,
  parameter int unsigned     INSTR_W = 16,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_W-1:0]     br_target,
  output logic [INSTR_W-1:0]  instr_q,
  output logic [ONEHOT_W-1:0] opcode_onehot,
  output logic                valid_q,
  output logic [PC_W-1:0]     pc_plus1,
  output logic                halted
);

  fd_state_t         state_q;
  logic [PC_W-1:0]   pc_q;
  logic [OP_W-1:0]   opcode;
  logic              halt_hit;

  assign opcode    = instr_q[INSTR_W-1 -: OP_W];
  assign halt_hit  = valid_q && (opcode == HALT_OP);
  assign imem_addr = pc_q;
  assign pc_plus1  = pc_q + PC_W'(1);
  assign halted    = (state_q == HALT);

  // Priority in RUN: halt > branch > stall > advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (halt_hit) begin
            state_q <= HALT;
            valid_q <= 1'b0;
          end else if (br_taken) begin
            pc_q    <= br_target;
            instr_q <= '0;
            valid_q <= 1'b0;
          end else if (!stall) begin
            pc_q    <= pc_plus1;
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
          end
        end
        HALT: valid_q <= 1'b0;
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  onehot_dec6 u_dec (
    .code   (opcode),
    .en     (valid_q),
    .onehot (opcode_onehot)
  );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage.
// Combinational imem model; all expectations are hand-computed constants.
module tb_fetch_decode_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [15:0] instr_q;
  logic [63:0] opcode_onehot;
  logic        valid_q;
  logic [7:0]  pc_plus1;
  logic        halted;

  logic [15:0] imem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];

  fetch_decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .instr_q       (instr_q),
    .opcode_onehot (opcode_onehot),
    .valid_q       (valid_q),
    .pc_plus1      (pc_plus1),
    .halted        (halted)
  );

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [9:0] lo);
    return {op, lo};
  endfunction

  function automatic logic [63:0] bit_of(input int n);
    logic [63:0] v;
    v = 64'd1;
    return v << n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"}, 64'(imem_addr), 64'h0);
    chk({tag, ".valid"}, 64'(valid_q), 64'h0);
    chk({tag, ".instr"}, 64'(instr_q), 64'h0);
    chk({tag, ".onehot"}, opcode_onehot, 64'h0);
    chk({tag, ".halted"}, 64'(halted), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = mk(OP_ADD, 10'(i));
    imem[0]    = mk(OP_ADD,  10'h011);
    imem[1]    = mk(OP_AND,  10'h022);
    imem[2]    = mk(OP_CMP,  10'h033);
    imem[3]    = mk(OP_MOVL, 10'h044);
    imem[4]    = mk(OP_ADD,  10'h055);
    imem[5]    = mk(OP_JA,   10'h040);
    imem[6]    = mk(OP_AND,  10'h066);
    imem[8'h40] = mk(OP_MOVS, 10'h140);
    imem[8'h80] = mk(OP_CMP,  10'h180);
    imem[8'hFF] = mk(OP_AND,  10'h1FF);

    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    step(); step();
    chk_reset("rst");

    // 1: boot then sequential fetch
    rst_n = 1'b1;
    step();
    chk("boot.addr", 64'(imem_addr), 64'h0);
    chk("boot.valid", 64'(valid_q), 64'h0);
    step();
    chk("f0.onehot", opcode_onehot, bit_of(4));
    chk("f0.valid", 64'(valid_q), 64'h1);
    chk("f0.addr", 64'(imem_addr), 64'h1);
    step();
    chk("f1.onehot", opcode_onehot, bit_of(25));
    chk("f1.addr", 64'(imem_addr), 64'h2);
    step();
    chk("f2.onehot", opcode_onehot, bit_of(59));
    chk("f2.addr", 64'(imem_addr), 64'h3);
    chk("f2.pc1", 64'(pc_plus1), 64'h4);
    step();
    chk("f3.instr", 64'(instr_q), 64'h3044);

    // 2: stall holds MOVL
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr", 64'(imem_addr), 64'h4);
      chk("stall.instr", 64'(instr_q), 64'h3044);
      chk("stall.onehot", opcode_onehot, bit_of(12));
    end
    stall = 1'b0;
    step();
    chk("resume.instr", 64'(instr_q), 64'h1055);
    chk("resume.addr", 64'(imem_addr), 64'h5);
    step();
    chk("ja.onehot", opcode_onehot, bit_of(14));

    // 3: branch taken
    br_taken = 1'b1; br_target = 8'h40;
    step();
    chk("br.valid", 64'(valid_q), 64'h0);
    chk("br.onehot", opcode_onehot, 64'h0);
    chk("br.addr", 64'(imem_addr), 64'h40);
    br_taken = 1'b0;
    step();
    chk("br.tgt_instr", 64'(instr_q), 64'h3540);
    chk("br.tgt_onehot", opcode_onehot, bit_of(13));
    chk("br.tgt_addr", 64'(imem_addr), 64'h41);

    // 4: branch beats stall
    br_taken = 1'b1; stall = 1'b1; br_target = 8'h80;
    step();
    chk("brst.valid", 64'(valid_q), 64'h0);
    chk("brst.addr", 64'(imem_addr), 64'h80);
    br_taken = 1'b0; stall = 1'b0;
    step();
    chk("brst.instr", 64'(instr_q), 64'hED80);
    chk("brst.addr2", 64'(imem_addr), 64'h81);

    // 5: wrap then HALT at 0
    br_taken = 1'b1; br_target = 8'hFF;
    step();
    chk("wrap.addr", 64'(imem_addr), 64'hFF);
    chk("wrap.pc1", 64'(pc_plus1), 64'h00);
    br_taken = 1'b0;
    imem[0] = mk(OP_HALT, 10'h000);
    step();
    chk("wrap.instr", 64'(instr_q), 64'h65FF);
    chk("wrap.addr2", 64'(imem_addr), 64'h00);
    chk("wrap.pc1b", 64'(pc_plus1), 64'h01);
    step();
    chk("hlt.onehot", opcode_onehot, bit_of(63));
    chk("hlt.addr", 64'(imem_addr), 64'h01);
    br_taken = 1'b1; br_target = 8'h22;
    step();
    chk("hlt.halted", 64'(halted), 64'h1);
    chk("hlt.valid", 64'(valid_q), 64'h0);
    chk("hlt.onehot0", opcode_onehot, 64'h0);
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step();
      chk("frz.addr", 64'(imem_addr), 64'h01);
      chk("frz.halted", 64'(halted), 64'h1);
      chk("frz.valid", 64'(valid_q), 64'h0);
    end
    br_taken = 1'b0; stall = 1'b0;

    // 6: reset out of HALT, then mid-RUN
    rst_n = 1'b0;
    step();
    chk_reset("rsth");
    imem[0] = mk(OP_ADD, 10'h011);
    rst_n = 1'b1;
    step();
    chk("rsth.boot_valid", 64'(valid_q), 64'h0);
    chk("rsth.boot_addr", 64'(imem_addr), 64'h0);
    step();
    chk("rsth.f0", opcode_onehot, bit_of(4));
    step();
    chk("run.f1", opcode_onehot, bit_of(25));
    rst_n = 1'b0;
    step();
    chk_reset("rstr");
    rst_n = 1'b1;
    step();
    chk("rstr.boot_valid", 64'(valid_q), 64'h0);
    step();
    chk("rstr.f0", opcode_onehot, bit_of(4));
    chk("rstr.addr", 64'(imem_addr), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
